// File: rtl/ahb_slv_rsp_mux_if.sv
// ahb_slv_rsp_mux_if: decoder select, master HTRANS, slave responses and muxed response to master
interface ahb_slv_rsp_mux_if #(parameter int SLV_NUM = 7, parameter int DATA_WIDTH = 32);
   logic [SLV_NUM-1:0]                 hsel_i;
   logic [1:0]                         htrans_i;
   logic [SLV_NUM-1:0][DATA_WIDTH-1:0] hrdata_s_i;
   logic [SLV_NUM-1:0]                 hreadyout_s_i;
   logic [SLV_NUM-1:0]                 hresp_s_i;
   logic [DATA_WIDTH-1:0]              hrdata_o;
   logic                               hready_o;
   logic                               hresp_o;
   logic                               sel_err_o;
   modport slave (input hsel_i, htrans_i, hrdata_s_i, hreadyout_s_i, hresp_s_i,
                  output hrdata_o, hready_o, hresp_o, sel_err_o);
   modport master (output hsel_i, htrans_i, hrdata_s_i, hreadyout_s_i, hresp_s_i,
                   input hrdata_o, hready_o, hresp_o, sel_err_o);
endinterface

// File: rtl/ahb_slv_rsp_mux.sv
// ahb_slv_rsp_mux: AHB-Lite response mux with data-phase select tracking and a built-in default slave
module ahb_slv_rsp_mux #(parameter int SLV_NUM = 7, parameter int DATA_WIDTH = 32) (
   input logic              HCLK,
   input logic              HRESETn,
   ahb_slv_rsp_mux_if.slave bus
);
   typedef enum logic [1:0] {NONE, SLV, ERR1, ERR2} mode_t;
   mode_t                 mode_q;
   logic [SLV_NUM-1:0]    dsel_q;
   logic                  sel_err_q;
   logic [DATA_WIDTH-1:0] rd;
   logic                  rdy, rsp, multi, onehot, active;
   assign active = bus.htrans_i[1];
   assign multi  = (bus.hsel_i & (bus.hsel_i - SLV_NUM'(1))) != '0;
   assign onehot = (|bus.hsel_i) & ~multi;
   // dsel_q is one-hot or zero, so a plain AND-OR needs no priority
   always_comb begin
      rd  = '0;
      rdy = 1'b0;
      rsp = 1'b0;
      for (int i = 0; i < SLV_NUM; i++) begin
         rd  = rd | ({DATA_WIDTH{dsel_q[i]}} & bus.hrdata_s_i[i]);
         rdy = rdy | (dsel_q[i] & bus.hreadyout_s_i[i]);
         rsp = rsp | (dsel_q[i] & bus.hresp_s_i[i]);
      end
   end
   assign bus.hrdata_o  = (mode_q == SLV) ? rd : '0;
   assign bus.hready_o  = (mode_q == SLV) ? rdy : (mode_q != ERR1);
   assign bus.hresp_o   = (mode_q == SLV) ? rsp : (mode_q == ERR1 || mode_q == ERR2);
   assign bus.sel_err_o = sel_err_q;
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         mode_q    <= NONE;
         dsel_q    <= '0;
         sel_err_q <= 1'b0;
      end else if (bus.hready_o) begin
         mode_q    <= onehot ? SLV : (active ? ERR1 : NONE);
         dsel_q    <= onehot ? bus.hsel_i : '0;
         sel_err_q <= multi;
      end else begin
         mode_q    <= (mode_q == ERR1) ? ERR2 : mode_q;
         sel_err_q <= 1'b0;
      end
endmodule
